// File: rtl/regfile_wb_queue_pkg.sv
// Shared widths and the queued write-back entry type.
package regfile_wb_queue_pkg;
   localparam int AW        = 5;
   localparam int DW        = 32;
   localparam int DEPTH_DEF = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/regfile_wb_queue_if.sv
// Result sources, register-file write port and bypass lookups of the write-back queue.
interface regfile_wb_queue_if
   import regfile_wb_queue_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) ();
   localparam int CW = $clog2(DEPTH) + 1;

   logic          mem_valid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_ready;
   logic          alu_valid;
   logic [AW-1:0] alu_addr;
   logic [DW-1:0] alu_data;
   logic          alu_ready;
   logic [AW-1:0] wb_addr;
   logic [DW-1:0] wb_data;
   logic          wb_we;
   logic [AW-1:0] lk1_addr;
   logic          lk1_hit;
   logic [DW-1:0] lk1_data;
   logic [AW-1:0] lk2_addr;
   logic          lk2_hit;
   logic [DW-1:0] lk2_data;
   logic [CW-1:0] count;
   logic          empty;

   // pipeline / bench side
   modport master (
      output mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
             lk1_addr, lk2_addr,
      input  mem_ready, alu_ready, wb_addr, wb_data, wb_we,
             lk1_hit, lk1_data, lk2_hit, lk2_data, count, empty
   );

   // queue side
   modport slave (
      input  mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data,
             lk1_addr, lk2_addr,
      output mem_ready, alu_ready, wb_addr, wb_data, wb_we,
             lk1_hit, lk1_data, lk2_hit, lk2_data, count, empty
   );
endinterface

// File: rtl/regfile_wb_match.sv
// Bypass search for one lookup port: youngest valid queued entry with a matching address.
module regfile_wb_match
   import regfile_wb_queue_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   localparam int PW   = $clog2(DEPTH)
) (
   input  wb_entry_t [DEPTH-1:0] ents,
   input  logic [DEPTH-1:0]      vld,
   input  logic [PW-1:0]         head,
   input  logic [AW-1:0]         addr,
   output logic                  hit,
   output logic [DW-1:0]         data
);
   logic [PW-1:0] idx;

   // Walk from head (oldest) towards tail; a later match overrides, so the youngest wins.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + PW'(k);
         if (vld[idx] && (ents[idx].addr == addr) && (addr != '0)) begin
            hit  = 1'b1;
            data = ents[idx].data;
         end
      end
   end
endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue: merges load and ALU results, retires one per clock to the
// register file write port, and exposes queued values to two decode-stage bypass ports.
module regfile_wb_queue
   import regfile_wb_queue_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   regfile_wb_queue_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   wb_entry_t [DEPTH-1:0] ents;
   logic [DEPTH-1:0]      vld;
   logic [PW-1:0]         head, tail, alu_slot;
   logic [CW-1:0]         cnt, free;
   logic                  mem_push, alu_push, pop;
   logic [1:0]            npush;

   // Readies come from registered occupancy only; a same-cycle pop never frees a slot.
   always_comb begin
      free          = CW'(DEPTH) - cnt;
      bus.mem_ready = (free >= CW'(1));
      bus.alu_ready = bus.mem_valid ? (free >= CW'(2)) : (free >= CW'(1));
      // r0 writes are acknowledged but dropped
      mem_push      = bus.mem_valid && bus.mem_ready && (bus.mem_addr != '0);
      alu_push      = bus.alu_valid && bus.alu_ready && (bus.alu_addr != '0);
      npush         = {1'b0, mem_push} + {1'b0, alu_push};
      // the load result is older, so it takes the tail slot when both push
      alu_slot      = mem_push ? tail + PW'(1) : tail;
      pop           = (cnt != '0);
   end

   // Retire from head; outputs are forced to zero when nothing is queued.
   always_comb begin
      bus.wb_we   = pop;
      bus.wb_addr = pop ? ents[head].addr : '0;
      bus.wb_data = pop ? ents[head].data : '0;
      bus.count   = cnt;
      bus.empty   = (cnt == '0);
   end

   // Pointers, occupancy and per-entry valid bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         vld  <= '0;
      end else begin
         if (pop)      vld[head]     <= 1'b0;
         if (mem_push) vld[tail]     <= 1'b1;
         if (alu_push) vld[alu_slot] <= 1'b1;
         head <= head + PW'(pop);
         tail <= tail + PW'(npush);
         cnt  <= cnt + CW'(npush) - CW'(pop);
      end
   end

   // Entry payloads; only meaningful where the valid bit is set, so no reset needed.
   always_ff @(posedge clk) begin
      if (mem_push) ents[tail]     <= '{addr: bus.mem_addr, data: bus.mem_data};
      if (alu_push) ents[alu_slot] <= '{addr: bus.alu_addr, data: bus.alu_data};
   end

   regfile_wb_match #(.DEPTH(DEPTH)) u_lk1 (
      .ents (ents),
      .vld  (vld),
      .head (head),
      .addr (bus.lk1_addr),
      .hit  (bus.lk1_hit),
      .data (bus.lk1_data)
   );

   regfile_wb_match #(.DEPTH(DEPTH)) u_lk2 (
      .ents (ents),
      .vld  (vld),
      .head (head),
      .addr (bus.lk2_addr),
      .hit  (bus.lk2_hit),
      .data (bus.lk2_data)
   );
endmodule
